softreg_ctrl: RTL and testbench
===============================

Name: softreg_ctrl

Overview:
- SoftReg responder and run controller inside PageRank; the host drives the softreg_req_* requests and this block answers them.
- Decodes host writes into parameter registers and launches the PageRank core on a DONE_READ_PARAMS write.
- Sequences N_ROUNDS rounds with ping-pong rank buffers.
- Answers host reads; a DONE_ALL read is held until the run finishes, then returned with the final rank sum.

Parameters:
- ADDR_W, 32, softreg address width
- DATA_W, 64, softreg data / parameter width
- RND_W, 16, round counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- softreg_req_valid  in  1  request strobe, one cycle per request
- softreg_req_isWrite  in  1  1 = write, 0 = read
- softreg_req_addr  in  ADDR_W  register address
- softreg_req_data  in  DATA_W  write data
- softreg_resp_valid  out  1  read response strobe
- softreg_resp_data  out  DATA_W  read response data
- n_vert, n_inedges, vaddr, ieaddr  out  DATA_W  latched parameters
- round_start  out  1  one-cycle pulse, begin a round
- rd_base  out  DATA_W  previous-ranks buffer address for the current round
- wr_base  out  DATA_W  new-ranks buffer address for the current round
- round_idx  out  RND_W  current round number
- round_done  in  1  core finished the current round (pulse)
- rank_sum  in  DATA_W  core's running total, valid with round_done
- busy  out  1  run in progress

Behaviour:
- Register map, in the shared constants header, byte addresses:
  - N_VERT 0x00, N_INEDGES 0x08, VADDR 0x10, IEADDR 0x18
  - WRITE_ADDR0 0x20, WRITE_ADDR1 0x28, N_ROUNDS 0x30
  - DONE_READ_PARAMS 0x38, DONE_ALL 0x40
- Reset (rst low, asynchronous): all parameter registers 0; state IDLE; round_idx 0; all pulses 0; softreg_resp_valid 0; softreg_resp_data 0; pending flag 0; result 0.
- States: IDLE, LAUNCH, RUN, DONE.
- Writes in IDLE or DONE update the addressed parameter register on the next clk edge.
- Writes in LAUNCH or RUN are ignored; parameters stay locked.
- Writes to unknown addresses are ignored.
- A DONE_READ_PARAMS write, data ignored:
  - if N_ROUNDS == 0: go to DONE with result 0;
  - otherwise: go to LAUNCH; round_idx := 0.
  - Also clears the result register and any pending DONE_ALL read.
- LAUNCH: round_start = 1 for exactly one cycle, then RUN. busy = 1 in LAUNCH and RUN.
- Ping-pong buffers:
  - round_idx even: wr_base = WRITE_ADDR0, rd_base = WRITE_ADDR1.
  - round_idx odd: swapped.
  - Combinational from round_idx.
- RUN, on round_done:
  - latch rank_sum into result; round_idx += 1;
  - if the new round_idx == N_ROUNDS: go to DONE;
  - otherwise: go to LAUNCH.
- round_done outside RUN is ignored.
- Register reads return the stored value, with softreg_resp_valid high exactly 1 cycle after the request:
  - parameter registers;
  - DONE_READ_PARAMS returns {63'b0, busy}.
- Reads of unknown addresses return 0 with the same 1-cycle latency.
- A DONE_ALL read:
  - in DONE: respond next cycle with result;
  - otherwise: set the pending flag, no response;
  - when DONE is entered with the flag set: respond in the cycle after entry with result, then clear the flag.
- Only one DONE_ALL read may be pending; further DONE_ALL reads while pending are dropped.
- Other reads while a read is pending are still answered normally.
- Simultaneous events: if a pending completion and a normal read response fall on the same cycle, the completion wins and the normal read response is dropped. The host issues no reads while waiting, so this case occurs only in directed tests.
- softreg_resp_valid is never high for more than one consecutive cycle per response.
- Reset mid-run: returns to IDLE immediately; no response is issued.

Decomposition:
- Address constants and state encoding go in the shared constants header beside the existing softreg defines.
- Single module. The ping-pong address mux is inline; no sub-module is needed.

Test Plan:
- Write N_VERT=10, N_INEDGES=56, VADDR=0, IEADDR=160, then read each -> resp_valid 1 cycle later with 10/56/0/160; unknown address 0x48 read -> 0.
- WRITE_ADDR0=640, WRITE_ADDR1=768, N_ROUNDS=8, DONE_READ_PARAMS:
  - round_start pulses 8 times;
  - wr_base alternates 640/768/640...;
  - rd_base is the opposite;
  - busy drops after the 8th round_done.
- DONE_ALL read at round 2, core returns rank_sum=1000 on the final round_done -> single resp_valid with 1000 one cycle after DONE entry.
- N_ROUNDS=0 then DONE_READ_PARAMS -> no round_start; DONE_ALL read returns 0 next cycle.
- Write N_VERT=99 during RUN -> read returns 10; round_done while IDLE -> round_idx unchanged.
- Assert rst low during round 3 -> busy 0, all outputs reset asynchronously; a fresh launch restarts at round_idx 0 with wr_base 640.

Source files
------------

// File: rtl/softreg_ctrl_pkg.sv
// Shared constants for the PageRank SoftReg controller: register map,
// run-state encoding and the address decoder used by the responder.
package softreg_ctrl_pkg;

  localparam logic [31:0] ADDR_N_VERT           = 32'h00;
  localparam logic [31:0] ADDR_N_INEDGES        = 32'h08;
  localparam logic [31:0] ADDR_VADDR            = 32'h10;
  localparam logic [31:0] ADDR_IEADDR           = 32'h18;
  localparam logic [31:0] ADDR_WRITE_ADDR0      = 32'h20;
  localparam logic [31:0] ADDR_WRITE_ADDR1      = 32'h28;
  localparam logic [31:0] ADDR_N_ROUNDS         = 32'h30;
  localparam logic [31:0] ADDR_DONE_READ_PARAMS = 32'h38;
  localparam logic [31:0] ADDR_DONE_ALL         = 32'h40;

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_RUN, ST_DONE} state_e;

  typedef enum logic [3:0] {
    REG_N_VERT, REG_N_INEDGES, REG_VADDR, REG_IEADDR,
    REG_WRITE_ADDR0, REG_WRITE_ADDR1, REG_N_ROUNDS,
    REG_DONE_READ_PARAMS, REG_DONE_ALL, REG_NONE
  } reg_e;

  // Exact byte-address match; anything else (including unaligned) is unknown.
  function automatic reg_e decode_reg(input logic [31:0] addr);
    case (addr)
      ADDR_N_VERT:           return REG_N_VERT;
      ADDR_N_INEDGES:        return REG_N_INEDGES;
      ADDR_VADDR:            return REG_VADDR;
      ADDR_IEADDR:           return REG_IEADDR;
      ADDR_WRITE_ADDR0:      return REG_WRITE_ADDR0;
      ADDR_WRITE_ADDR1:      return REG_WRITE_ADDR1;
      ADDR_N_ROUNDS:         return REG_N_ROUNDS;
      ADDR_DONE_READ_PARAMS: return REG_DONE_READ_PARAMS;
      ADDR_DONE_ALL:         return REG_DONE_ALL;
      default:               return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/softreg_ctrl.sv
// SoftReg responder and round sequencer for the PageRank core: latches host
// parameters, runs N_ROUNDS ping-pong rounds and holds a DONE_ALL read until completion.
module softreg_ctrl
  import softreg_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int RND_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              softreg_req_valid,
  input  logic              softreg_req_isWrite,
  input  logic [ADDR_W-1:0] softreg_req_addr,
  input  logic [DATA_W-1:0] softreg_req_data,
  output logic              softreg_resp_valid,
  output logic [DATA_W-1:0] softreg_resp_data,
  output logic [DATA_W-1:0] n_vert,
  output logic [DATA_W-1:0] n_inedges,
  output logic [DATA_W-1:0] vaddr,
  output logic [DATA_W-1:0] ieaddr,
  output logic              round_start,
  output logic [DATA_W-1:0] rd_base,
  output logic [DATA_W-1:0] wr_base,
  output logic [RND_W-1:0]  round_idx,
  input  logic              round_done,
  input  logic [DATA_W-1:0] rank_sum,
  output logic              busy
);

  state_e            r_state, w_next;
  logic [DATA_W-1:0] r_n_vert, r_n_inedges, r_vaddr, r_ieaddr;
  logic [DATA_W-1:0] r_waddr0, r_waddr1, r_n_rounds, r_result;
  logic [RND_W-1:0]  r_round_idx;
  logic              r_pending, r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;

  reg_e              w_reg;
  logic              w_wr, w_rd, w_params_open, w_launch_req, w_round_end, w_last_round;
  logic [RND_W-1:0]  w_round_idx_inc;
  logic [DATA_W-1:0] w_rd_data;

  assign w_reg           = decode_reg(32'(softreg_req_addr));
  assign w_wr            = softreg_req_valid &  softreg_req_isWrite;
  assign w_rd            = softreg_req_valid & ~softreg_req_isWrite;
  assign w_params_open   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_launch_req    = w_wr && w_params_open && (w_reg == REG_DONE_READ_PARAMS);
  assign w_round_end     = (r_state == ST_RUN) && round_done;
  assign w_round_idx_inc = r_round_idx + RND_W'(1);
  assign w_last_round    = {{(DATA_W-RND_W){1'b0}}, w_round_idx_inc} == r_n_rounds;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_launch_req) w_next = (r_n_rounds == '0) ? ST_DONE : ST_LAUNCH;
      ST_LAUNCH:        w_next = ST_RUN;
      ST_RUN:           if (round_done) w_next = w_last_round ? ST_DONE : ST_LAUNCH;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    case (w_reg)
      REG_N_VERT:           w_rd_data = r_n_vert;
      REG_N_INEDGES:        w_rd_data = r_n_inedges;
      REG_VADDR:            w_rd_data = r_vaddr;
      REG_IEADDR:           w_rd_data = r_ieaddr;
      REG_WRITE_ADDR0:      w_rd_data = r_waddr0;
      REG_WRITE_ADDR1:      w_rd_data = r_waddr1;
      REG_N_ROUNDS:         w_rd_data = r_n_rounds;
      REG_DONE_READ_PARAMS: w_rd_data = {{(DATA_W-1){1'b0}}, busy};
      REG_DONE_ALL:         w_rd_data = r_result;
      default:              w_rd_data = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_n_vert    <= '0;
      r_n_inedges <= '0;
      r_vaddr     <= '0;
      r_ieaddr    <= '0;
      r_waddr0    <= '0;
      r_waddr1    <= '0;
      r_n_rounds  <= '0;
      r_result    <= '0;
      r_round_idx <= '0;
    end else begin
      r_state <= w_next;
      if (w_wr && w_params_open) begin
        case (w_reg)
          REG_N_VERT:      r_n_vert    <= softreg_req_data;
          REG_N_INEDGES:   r_n_inedges <= softreg_req_data;
          REG_VADDR:       r_vaddr     <= softreg_req_data;
          REG_IEADDR:      r_ieaddr    <= softreg_req_data;
          REG_WRITE_ADDR0: r_waddr0    <= softreg_req_data;
          REG_WRITE_ADDR1: r_waddr1    <= softreg_req_data;
          REG_N_ROUNDS:    r_n_rounds  <= softreg_req_data;
          default:         ;
        endcase
      end
      if (w_launch_req) begin
        r_round_idx <= '0;
        r_result    <= '0;
      end else if (w_round_end) begin
        r_round_idx <= w_round_idx_inc;
        r_result    <= rank_sum;
      end
    end
  end

  // A pending DONE_ALL can only exist on the first DONE cycle; it pre-empts a normal read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (r_state == ST_DONE && r_pending) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= r_result;
        r_pending    <= 1'b0;
      end else if (w_rd) begin
        if (w_reg == REG_DONE_ALL && r_state != ST_DONE) begin
          r_pending <= 1'b1;
        end else begin
          r_resp_valid <= 1'b1;
          r_resp_data  <= w_rd_data;
        end
      end
      if (w_launch_req) r_pending <= 1'b0;
    end
  end

  assign softreg_resp_valid = r_resp_valid;
  assign softreg_resp_data  = r_resp_data;
  assign n_vert             = r_n_vert;
  assign n_inedges          = r_n_inedges;
  assign vaddr              = r_vaddr;
  assign ieaddr             = r_ieaddr;
  assign round_idx          = r_round_idx;
  assign round_start        = (r_state == ST_LAUNCH);
  assign busy               = (r_state == ST_LAUNCH) || (r_state == ST_RUN);
  assign wr_base            = r_round_idx[0] ? r_waddr1 : r_waddr0;
  assign rd_base            = r_round_idx[0] ? r_waddr0 : r_waddr1;

endmodule

// File: tb/tb_softreg_ctrl.sv
// Self-checking bench for softreg_ctrl: host register traffic and a simple core
// emulator, checked against a register-map model kept in the bench.
module tb_softreg_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int RND_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              softreg_req_valid = 1'b0;
  logic              softreg_req_isWrite = 1'b0;
  logic [ADDR_W-1:0] softreg_req_addr = '0;
  logic [DATA_W-1:0] softreg_req_data = '0;
  logic              softreg_resp_valid;
  logic [DATA_W-1:0] softreg_resp_data;
  logic [DATA_W-1:0] n_vert, n_inedges, vaddr, ieaddr, rd_base, wr_base;
  logic              round_start, busy;
  logic [RND_W-1:0]  round_idx;
  logic              round_done = 1'b0;
  logic [DATA_W-1:0] rank_sum = '0;

  softreg_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RND_W(RND_W)) dut (
    .clk(clk), .rst(rst),
    .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
    .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
    .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data),
    .n_vert(n_vert), .n_inedges(n_inedges), .vaddr(vaddr), .ieaddr(ieaddr),
    .round_start(round_start), .rd_base(rd_base), .wr_base(wr_base),
    .round_idx(round_idx), .round_done(round_done), .rank_sum(rank_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  always @(posedge clk) if (round_start) start_cnt++;

  // Model of the seven parameter registers, indexed by byte address / 8.
  logic [DATA_W-1:0] m_reg [0:6];

  // Issue one request starting at a negedge; returns on the next negedge.
  task automatic send_req(input logic wr, input logic [31:0] addr, input logic [63:0] data);
    softreg_req_valid   = 1'b1;
    softreg_req_isWrite = wr;
    softreg_req_addr    = addr;
    softreg_req_data    = data;
    @(negedge clk);
    softreg_req_valid   = 1'b0;
    softreg_req_isWrite = 1'b0;
  endtask

  task automatic host_write(input logic [31:0] addr, input logic [63:0] data, input bit open);
    send_req(1'b1, addr, data);
    if (open && addr <= 32'h30 && addr[2:0] == 3'd0) m_reg[addr[5:3]] = data;
  endtask

  // Read and return response seen one cycle later plus valid on the following cycle.
  task automatic host_read(input logic [31:0] addr, output logic v, output logic [63:0] d,
                           output logic v_next);
    send_req(1'b0, addr, '0);
    v = softreg_resp_valid;
    d = softreg_resp_data;
    @(negedge clk);
    v_next = softreg_resp_valid;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (round_start === 1'b1) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_done(input logic [63:0] v);
    round_done = 1'b1;
    rank_sum   = v;
    @(negedge clk);
    round_done = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({softreg_resp_valid, round_start, busy} !== 3'b000 || softreg_resp_data !== '0 ||
        n_vert !== '0 || n_inedges !== '0 || vaddr !== '0 || ieaddr !== '0 ||
        round_idx !== '0 || rd_base !== '0 || wr_base !== '0) begin
      errors++;
      $display("FAIL reset_state: resp_v=%0b start=%0b busy=%0b idx=%0d n_vert=%0h wr=%0h, required all 0",
               softreg_resp_valid, round_start, busy, round_idx, n_vert, wr_base);
    end
    for (int i = 0; i < 7; i++) m_reg[i] = '0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_param_rw();
    logic v, vn;
    logic [63:0] d;
    logic [63:0] spec_vals [0:3];
    for (int k = 0; k < 16; k++) begin
      int idx = $urandom_range(0, 6);
      host_write(32'(idx * 8), {$urandom, $urandom}, 1'b1);
      host_write(32'h48 + 32'($urandom_range(0, 20) * 8), {$urandom, $urandom}, 1'b1);
    end
    for (int i = 0; i < 7; i++) begin
      host_read(32'(i * 8), v, d, vn);
      checks++;
      if (v !== 1'b1 || d !== m_reg[i] || vn !== 1'b0) begin
        errors++;
        $display("FAIL rand_read[%0d]: valid=%0b next=%0b data=%0h, required 1/0/%0h", i, v, vn, d, m_reg[i]);
      end
    end
    spec_vals[0] = 64'd10; spec_vals[1] = 64'd56; spec_vals[2] = 64'd0; spec_vals[3] = 64'd160;
    for (int i = 0; i < 4; i++) host_write(32'(i * 8), spec_vals[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      host_read(32'(i * 8), v, d, vn);
      checks++;
      if (v !== 1'b1 || d !== spec_vals[i] || vn !== 1'b0) begin
        errors++;
        $display("FAIL param_read[%0d]: valid=%0b next=%0b data=%0d, required 1/0/%0d", i, v, vn, d, spec_vals[i]);
      end
    end
    checks++;
    if (n_vert !== 64'd10 || ieaddr !== 64'd160) begin
      errors++;
      $display("FAIL param_ports: n_vert=%0d ieaddr=%0d, required 10/160", n_vert, ieaddr);
    end
    host_read(32'h48, v, d, vn);
    checks++;
    if (v !== 1'b1 || d !== '0) begin
      errors++;
      $display("FAIL unknown_read_48: valid=%0b data=%0h, required 1/0", v, d);
    end
    host_read(32'h0c, v, d, vn);
    checks++;
    if (v !== 1'b1 || d !== '0) begin
      errors++;
      $display("FAIL unknown_read_0c: valid=%0b data=%0h, required 1/0", v, d);
    end
  endtask

  // Eight rounds with a pending DONE_ALL, a dropped duplicate, and locked-parameter writes.
  task automatic test_run_8();
    logic v, vn;
    logic [63:0] d, exp_wr, exp_rd, sum;
    bit ok;
    int s0;
    host_write(32'h20, 64'd640, 1'b1);
    host_write(32'h28, 64'd768, 1'b1);
    host_write(32'h30, 64'd8, 1'b1);
    s0 = start_cnt;
    host_write(32'h38, {$urandom, $urandom}, 1'b0);
    for (int r = 0; r < 8; r++) begin
      wait_start(ok);
      exp_wr = (r % 2 == 0) ? m_reg[4] : m_reg[5];
      exp_rd = (r % 2 == 0) ? m_reg[5] : m_reg[4];
      checks++;
      if (!ok || round_idx !== RND_W'(r) || wr_base !== exp_wr || rd_base !== exp_rd || busy !== 1'b1) begin
        errors++;
        $display("FAIL round_%0d: seen=%0b idx=%0d wr=%0d rd=%0d busy=%0b, required idx=%0d wr=%0d rd=%0d busy=1",
                 r, ok, round_idx, wr_base, rd_base, busy, r, exp_wr, exp_rd);
      end
      @(negedge clk);
      if (r == 2 || r == 4) begin
        host_read(32'h40, v, d, vn);
        checks++;
        if (v !== 1'b0 || vn !== 1'b0) begin
          errors++;
          $display("FAIL done_all_held_r%0d: valid=%0b next=%0b, required 0/0", r, v, vn);
        end
      end
      if (r == 5) begin
        host_write(32'h00, 64'd99, 1'b0);
        host_write(32'h20, 64'd1, 1'b0);
        host_read(32'h00, v, d, vn);
        checks++;
        if (v !== 1'b1 || d !== m_reg[0] || n_vert !== m_reg[0]) begin
          errors++;
          $display("FAIL locked_n_vert: valid=%0b data=%0d port=%0d, required 1/%0d", v, d, n_vert, m_reg[0]);
        end
        host_read(32'h38, v, d, vn);
        checks++;
        if (v !== 1'b1 || d !== 64'd1) begin
          errors++;
          $display("FAIL busy_read: valid=%0b data=%0h, required 1/1", v, d);
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sum = (r == 7) ? 64'd1000 : {$urandom, $urandom};
      pulse_done(sum);
    end
    checks++;
    if (busy !== 1'b0 || softreg_resp_valid !== 1'b0 || start_cnt - s0 != 8 || round_idx !== RND_W'(8)) begin
      errors++;
      $display("FAIL run_end: busy=%0b resp_v=%0b starts=%0d idx=%0d, required 0/0/8/8",
               busy, softreg_resp_valid, start_cnt - s0, round_idx);
    end
    @(negedge clk);
    checks++;
    if (softreg_resp_valid !== 1'b1 || softreg_resp_data !== 64'd1000) begin
      errors++;
      $display("FAIL done_all_release: valid=%0b data=%0d, required 1/1000", softreg_resp_valid, softreg_resp_data);
    end
    @(negedge clk);
    checks++;
    if (softreg_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_all_single: valid=%0b, required 0", softreg_resp_valid);
    end
    host_read(32'h40, v, d, vn);
    checks++;
    if (v !== 1'b1 || d !== 64'd1000 || vn !== 1'b0) begin
      errors++;
      $display("FAIL done_all_direct: valid=%0b data=%0d next=%0b, required 1/1000/0", v, d, vn);
    end
  endtask

  task automatic test_zero_rounds();
    logic v, vn;
    logic [63:0] d;
    int s0;
    host_write(32'h30, 64'd0, 1'b1);
    s0 = start_cnt;
    host_write(32'h38, 64'd0, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (start_cnt != s0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_rounds_idle: starts=%0d busy=%0b, required 0/0", start_cnt - s0, busy);
    end
    host_read(32'h40, v, d, vn);
    checks++;
    if (v !== 1'b1 || d !== '0 || vn !== 1'b0) begin
      errors++;
      $display("FAIL zero_rounds_result: valid=%0b data=%0d next=%0b, required 1/0/0", v, d, vn);
    end
  endtask

  task automatic test_reset_mid_run();
    logic v, vn;
    logic [63:0] d;
    bit ok;
    int seen;
    host_write(32'h30, 64'($urandom_range(5, 9)), 1'b1);
    host_write(32'h38, 64'd0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      wait_start(ok);
      @(negedge clk);
      if (r == 1) host_read(32'h40, v, d, vn);
      pulse_done({$urandom, $urandom});
    end
    wait_start(ok);
    @(negedge clk);
    checks++;
    if (!ok || round_idx !== RND_W'(3) || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_round3: seen=%0b idx=%0d busy=%0b, required 1/3/1", ok, round_idx, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || round_idx !== '0 || wr_base !== '0 || rd_base !== '0 || n_vert !== '0 ||
        round_start !== 1'b0 || softreg_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%0b idx=%0d wr=%0d n_vert=%0d resp_v=%0b, required all 0",
               busy, round_idx, wr_base, n_vert, softreg_resp_valid);
    end
    for (int i = 0; i < 7; i++) m_reg[i] = '0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (softreg_resp_valid === 1'b1) seen++;
    end
    pulse_done(64'd5);
    checks++;
    if (seen != 0 || round_idx !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: responses=%0d idx=%0d busy=%0b, required 0/0/0", seen, round_idx, busy);
    end
    host_write(32'h20, 64'd640, 1'b1);
    host_write(32'h28, 64'd768, 1'b1);
    host_write(32'h30, 64'd2, 1'b1);
    host_write(32'h38, 64'd0, 1'b0);
    wait_start(ok);
    checks++;
    if (!ok || round_idx !== '0 || wr_base !== 64'd640 || rd_base !== 64'd768) begin
      errors++;
      $display("FAIL relaunch: seen=%0b idx=%0d wr=%0d rd=%0d, required 1/0/640/768", ok, round_idx, wr_base, rd_base);
    end
    @(negedge clk);
    pulse_done(64'd7);
    wait_start(ok);
    @(negedge clk);
    pulse_done(64'd77);
    host_read(32'h40, v, d, vn);
    checks++;
    if (busy !== 1'b0 || v !== 1'b1 || d !== 64'd77) begin
      errors++;
      $display("FAIL relaunch_done: busy=%0b valid=%0b data=%0d, required 0/1/77", busy, v, d);
    end
  endtask

  initial begin
    test_reset();
    test_param_rw();
    test_run_8();
    test_zero_rounds();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
